multi_nbit_serial: RTL and testbench

Parametrised bit-serial multiplier and successor to the fixed 4-bit serial multiplier. It accepts two N-bit operands LSB-first on single-bit inputs under a START handshake, then computes the 2N-bit product with an internal shift-add datapath. It returns the product LSB-first on a single-bit output, qualified by a valid strobe. Unsigned or two's-complement mode is selected by parameter. It sits between serial operand sources and a serial result consumer in the arithmetic test designs.

---
 rtl/multi_nbit_serial.sv | 152 +++++++++++++++
 tb/tb_multi_nbit_serial.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multi_nbit_serial.sv
// Bit-serial N x N multiplier: operands arrive LSB-first, a shift-add core forms the
// 2N-bit product (unsigned or two's-complement), and the product leaves LSB-first.
module multi_nbit_serial #(
    parameter int N      = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       A,
    input  logic       B,
    output logic       BUSY,
    output logic       O,
    output logic       O_VALID,
    output logic       DONE,
    output logic [1:0] o_dbg_state
);

    localparam int PW = 2 * N;
    localparam int CW = $clog2(PW) + 1;

    localparam logic [CW-1:0] C_ZERO     = '0;
    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_LAST_OP  = CW'(N - 1);
    localparam logic [CW-1:0] C_LAST_BIT = CW'(PW - 1);
    localparam logic [CW-1:0] C_OUT_END  = CW'(PW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MUL  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [PW-1:0] r_p;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_o;
    logic          r_valid;
    logic          r_done;

    logic          w_last_op;
    logic          w_neg_step;
    logic [PW-1:0] w_a_ext;
    logic [PW-1:0] w_addend;
    logic [PW-1:0] w_acc_next;

    assign w_last_op = (r_cnt == C_LAST_OP);
    assign w_a_ext   = SIGNED ? {{N{r_a[N-1]}}, r_a} : {{N{1'b0}}, r_a};
    assign w_addend  = w_a_ext << r_cnt;

    // In signed mode B's top bit carries weight -2^(N-1), so that partial product is subtracted.
    assign w_neg_step = SIGNED && w_last_op;

    always_comb begin
        w_acc_next = r_p;
        if (r_b[0]) begin
            w_acc_next = w_neg_step ? (r_p - w_addend) : (r_p + w_addend);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (START)                w_next_state = S_LOAD;
            S_LOAD: if (w_last_op)            w_next_state = S_MUL;
            S_MUL:  if (w_last_op)            w_next_state = S_OUT;
            S_OUT:  if (r_cnt == C_OUT_END)   w_next_state = S_IDLE;
            default:                          w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_o     <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_a    <= {A, r_a[N-1:1]};
                        r_b    <= {B, r_b[N-1:1]};
                        r_p    <= '0;
                        r_cnt  <= C_ONE;
                        r_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_a   <= {A, r_a[N-1:1]};
                    r_b   <= {B, r_b[N-1:1]};
                    r_cnt <= w_last_op ? C_ZERO : (r_cnt + C_ONE);
                end
                S_MUL: begin
                    // r_b is consumed from its LSB; r_cnt is the weight of the current B bit.
                    r_p <= w_acc_next;
                    r_b <= r_b >> 1;
                    if (w_last_op) begin
                        r_o     <= w_acc_next[0];
                        r_valid <= 1'b1;
                        r_cnt   <= C_ONE;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                S_OUT: begin
                    // r_cnt counts product bits already presented; one extra cycle retires the op.
                    if (r_cnt == C_OUT_END) begin
                        r_o     <= 1'b0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_cnt   <= C_ZERO;
                    end else begin
                        r_p    <= r_p >> 1;
                        r_o    <= r_p[1];
                        r_done <= (r_cnt == C_LAST_BIT);
                        r_cnt  <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY        = r_busy;
    assign O           = r_o;
    assign O_VALID     = r_valid;
    assign DONE        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multi_nbit_serial.sv
// Directed bench for multi_nbit_serial: unsigned N=4, signed N=4 and unsigned N=8 instances,
// with cycle-exact checks of BUSY/O_VALID/O/DONE and the reassembled product.
module tb_multi_nbit_serial;

    logic       clk;
    logic       rst;
    logic [2:0] start_v;
    logic       a_in;
    logic       b_in;

    logic       busy_u4, o_u4, valid_u4, done_u4;
    logic       busy_s4, o_s4, valid_s4, done_s4;
    logic       busy_u8, o_u8, valid_u8, done_u8;
    logic [1:0] st_u4, st_s4, st_u8;

    int         mon_sel;
    logic       mon_busy, mon_o, mon_valid, mon_done;
    logic [1:0] mon_state;

    int         n_checks;
    int         n_errors;
    logic       exp_q[$];

    multi_nbit_serial #(.N(4), .SIGNED(1'b0)) u_u4 (
        .CLK(clk), .RST(rst), .START(start_v[0]), .A(a_in), .B(b_in),
        .BUSY(busy_u4), .O(o_u4), .O_VALID(valid_u4), .DONE(done_u4), .o_dbg_state(st_u4)
    );

    multi_nbit_serial #(.N(4), .SIGNED(1'b1)) u_s4 (
        .CLK(clk), .RST(rst), .START(start_v[1]), .A(a_in), .B(b_in),
        .BUSY(busy_s4), .O(o_s4), .O_VALID(valid_s4), .DONE(done_s4), .o_dbg_state(st_s4)
    );

    multi_nbit_serial #(.N(8), .SIGNED(1'b0)) u_u8 (
        .CLK(clk), .RST(rst), .START(start_v[2]), .A(a_in), .B(b_in),
        .BUSY(busy_u8), .O(o_u8), .O_VALID(valid_u8), .DONE(done_u8), .o_dbg_state(st_u8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mon_busy  = busy_u4;
        mon_o     = o_u4;
        mon_valid = valid_u4;
        mon_done  = done_u4;
        mon_state = st_u4;
        case (mon_sel)
            1: begin
                mon_busy = busy_s4; mon_o = o_s4; mon_valid = valid_s4;
                mon_done = done_s4; mon_state = st_s4;
            end
            2: begin
                mon_busy = busy_u8; mon_o = o_u8; mon_valid = valid_u8;
                mon_done = done_u8; mon_state = st_u8;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},  mon_busy,  1'b0);
        check({tag, " valid"}, mon_valid, 1'b0);
        check({tag, " o"},     mon_o,     1'b0);
        check({tag, " done"},  mon_done,  1'b0);
        check({tag, " state"}, mon_state, 2'd0);
    endtask

    // Driver + per-cycle checker. Entered and left just after a falling edge.
    // poke: pulse START during MUL, OUT and at the last OUT edge (all must be ignored).
    // abort_at: after the checks for edge k+abort_at, assert RST for one edge (-1 = never).
    task automatic run_op(input int sel, input int n, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_p, input bit poke, input int abort_at,
                          input string name);
        logic [63:0] got;
        logic        exp_busy, exp_valid, exp_done, exp_o;
        got     = '0;
        mon_sel = sel;
        exp_q.delete();
        for (int i = 0; i < 2 * n; i++) exp_q.push_back(exp_p[i]);

        start_v      = '0;
        start_v[sel] = 1'b1;
        a_in         = a[0];
        b_in         = b[0];
        for (int j = 0; j <= 4 * n - 1; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j >= 1) begin
                exp_busy  = (j <= 4 * n - 2);
                exp_valid = (j >= 2 * n - 1) && (j <= 4 * n - 2);
                exp_done  = (j == 4 * n - 2);
                exp_o     = exp_valid ? exp_q.pop_front() : 1'b0;
                if (exp_valid) got[j - (2 * n - 1)] = mon_o;
                check($sformatf("%s busy e%0d", name, j),  mon_busy,  exp_busy);
                check($sformatf("%s valid e%0d", name, j), mon_valid, exp_valid);
                check($sformatf("%s done e%0d", name, j),  mon_done,  exp_done);
                check($sformatf("%s o e%0d", name, j),     mon_o,     exp_o);
            end
            start_v[sel] = poke && ((j + 1 == n + 1) || (j + 1 == 2 * n + 1) || (j + 1 == 4 * n - 1));
            if (j + 1 < n) begin
                a_in = a[j + 1];
                b_in = b[j + 1];
            end else begin
                a_in = 1'($urandom_range(0, 1));
                b_in = 1'($urandom_range(0, 1));
            end
            if (j == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check_idle_outputs({name, " after rst"});
                rst     = 1'b0;
                start_v = '0;
                exp_q.delete();
                return;
            end
        end
        start_v = '0;
        check({name, " product"}, got, exp_p);
        if (poke) begin
            @(posedge clk);
            @(negedge clk);
            check({name, " no 2nd op busy"},  mon_busy,  1'b0);
            check({name, " no 2nd op valid"}, mon_valid, 1'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_sel  = 0;
        rst      = 1'b1;
        start_v  = '0;
        a_in     = 1'b0;
        b_in     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            mon_sel = s;
            #0;
            check_idle_outputs($sformatf("reset dut%0d", s));
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        run_op(0, 4, 32'hF, 32'hF, 64'hE1, 1'b0, -1, "u4 15x15");
        run_op(1, 4, 32'h8, 32'h8, 64'h40, 1'b0, -1, "s4 -8x-8");
        run_op(1, 4, 32'hF, 32'h1, 64'hFF, 1'b0, -1, "s4 -1x1");
        run_op(1, 4, 32'h7, 32'h8, 64'hC8, 1'b0, -1, "s4 7x-8");
        run_op(0, 4, 32'h0, 32'hB, 64'h00, 1'b0, -1, "u4 0x11");
        run_op(0, 4, 32'h3, 32'h5, 64'h0F, 1'b0, -1, "u4 b2b 3x5");
        run_op(0, 4, 32'hD, 32'hB, 64'h8F, 1'b1, -1, "u4 poke 13x11");
        run_op(0, 4, 32'h5, 32'h6, 64'h1E, 1'b0, 9,  "u4 abort");
        run_op(0, 4, 32'h2, 32'h3, 64'h06, 1'b0, -1, "u4 2x3");
        run_op(2, 8, 32'hFF, 32'hFF, 64'hFE01, 1'b0, -1, "u8 255x255");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
